// File: rtl/button_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared constants for the pushbutton conditioner and the CPU-facing button
// block that samples its outputs. Both sides refer to button levels by name
// so the active-low polarity of the board pins is defined in one place.
//
// Contents:
//   BTN_PRESSED              level of a pressed button (pins are active-low)
//   BTN_RELEASED             level of a released button
//   DEFAULT_NUM_BUTTONS      default channel count
//   DEFAULT_DEBOUNCE_CYCLES  default stable-time requirement (10 ms @ 25 MHz)
//   debounce_cnt_w()         width of a counter able to hold 0..cycles
// ----------------------------------------------------------------------------
package button_pkg;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    localparam int DEFAULT_NUM_BUTTONS     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // Counter width for a given stable-time requirement. One extra count of
    // headroom keeps the width non-zero when the requirement is a single cycle.
    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the per-button signals that flow between the board pins, the
// conditioner and its consumer. One bit per button in every vector.
//
// Signals:
//   btn_raw        raw pin levels, active-low, asynchronous to clk
//   sticky_clr     per-channel clear request for press_sticky (level)
//   btn_clean      debounced level, active-low
//   press_pulse    one-cycle pulse on a clean press
//   release_pulse  one-cycle pulse on a clean release
//   press_sticky   latched press flag, held until cleared
//
// Modports:
//   master  the side that supplies raw pins / clears and consumes the results
//   slave   the conditioner itself
// ----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int NUM_BUTTONS = 2
);

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] sticky_clr;
    logic [NUM_BUTTONS-1:0] btn_clean;
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;
    logic [NUM_BUTTONS-1:0] press_sticky;

    modport master (
        output btn_raw,
        output sticky_clr,
        input  btn_clean,
        input  press_pulse,
        input  release_pulse,
        input  press_sticky
    );

    modport slave (
        input  btn_raw,
        input  sticky_clr,
        output btn_clean,
        output press_pulse,
        output release_pulse,
        output press_sticky
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// ----------------------------------------------------------------------------
// button_debounce_channel
// Conditions a single active-low pushbutton: two-flop synchroniser, stable-time
// debounce counter, clean level, registered press/release pulses and a sticky
// press flag.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   btn_raw        raw pin level, active-low, asynchronous to clk
//   sticky_clr     clears press_sticky on an edge where it is high
//   btn_clean      debounced level, active-low
//   press_pulse    one-cycle pulse on the edge btn_clean goes 1->0
//   release_pulse  one-cycle pulse on the edge btn_clean goes 0->1
//   press_sticky   set with press_pulse, held until cleared
// ----------------------------------------------------------------------------
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic sticky_clr,
    output logic btn_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_sticky
);

    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);

    // Last count value before the clean level is allowed to flip. The counter
    // never goes past this, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             clean_q;
    logic             clean_next;
    logic             press_q;
    logic             press_next;
    logic             rel_q;
    logic             rel_next;
    logic             sticky_q;
    logic             sticky_next;

    // Synchroniser flops reset to the released level so that leaving reset
    // with a button already held looks like a fresh press, not a glitch.
    // Event pulses reset low, so reset itself never produces an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= BTN_RELEASED;
            sync2_q  <= BTN_RELEASED;
            cnt_q    <= '0;
            clean_q  <= BTN_RELEASED;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_next;
            clean_q  <= clean_next;
            press_q  <= press_next;
            rel_q    <= rel_next;
            sticky_q <= sticky_next;
        end
    end

    // Stable-time counting: any cycle where the synchronised level agrees
    // with the clean level throws the accumulated count away, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing cycles flips the output.
    // The pulses are computed alongside the new clean level so they line up
    // with the cycle in which btn_clean changes.
    always_comb begin
        cnt_next   = '0;
        clean_next = clean_q;
        press_next = 1'b0;
        rel_next   = 1'b0;

        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_TERMINAL) begin
                clean_next = sync2_q;
                press_next = (sync2_q == BTN_PRESSED);
                rel_next   = (sync2_q == BTN_RELEASED);
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

    // A press arriving on the same edge as a clear must not be lost, so the
    // set term is applied after the clear term.
    always_comb begin
        sticky_next = sticky_q;
        if (sticky_clr) begin
            sticky_next = 1'b0;
        end
        if (press_next) begin
            sticky_next = 1'b1;
        end
    end

    assign btn_clean     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign press_sticky  = sticky_q;

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Front end for the board pushbuttons. Each button gets its own independent
// debounce channel; there is no logic shared between channels.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    button_conditioner_if.slave carrying btn_raw / sticky_clr in and
//          btn_clean / press_pulse / release_pulse / press_sticky out
//
// Parameters:
//   NUM_BUTTONS      number of channels; must match the interface width
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to change btn_clean
// ----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .btn_raw       (bus.btn_raw[i]),
            .sticky_clr    (bus.sticky_clr[i]),
            .btn_clean     (bus.btn_clean[i]),
            .press_pulse   (bus.press_pulse[i]),
            .release_pulse (bus.release_pulse[i]),
            .press_sticky  (bus.press_sticky[i])
        );
    end

endmodule
